// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and datapath-select encodings for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  // first execute state for an opcode; bad is returned for unsupported opcodes
  function automatic state_e decode_state(input logic [5:0] op, input state_e bad);
    return (op == OP_LW || op == OP_SW) ? S_MEMADR :
           op == OP_RTYPE ? S_EXEC :
           op == OP_BEQ   ? S_BRANCH :
           op == OP_ADDI  ? S_ADDIEX :
           op == OP_J     ? S_JUMP : bad;
  endfunction
endpackage

// File: rtl/mc_mem_wait_timer.sv
// mc_mem_wait_timer: counts consecutive memory wait cycles and pulses mem_err at MEM_TIMEOUT (0 = off)
module mc_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_cyc,
  input  logic clr,
  output logic mem_err
);
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = MEM_TIMEOUT > 0 ? CW'(MEM_TIMEOUT - 1) : '0;
  logic [CW-1:0] cnt_q, cnt_d;
  // error fires on the wait cycle that completes the budget; the count restarts after it
  always_comb begin
    mem_err = (MEM_TIMEOUT > 0) && wait_cyc && !clr && cnt_q == LAST;
    cnt_d = (!wait_cyc || clr || mem_err) ? '0 : cnt_q + CW'(1);
  end
  // wait counter register
  always_ff @(posedge clk) begin
    cnt_q <= !rst_n ? '0 : cnt_d;
  end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore control FSM of the multicycle MIPS subset; MC_CTRL_ILLEGAL_TRAP_EN traps unsupported opcodes
module multicycle_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_write,
  output logic            iord,
  output logic            ir_write,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic [1:0]      pcsrc,
  output logic            ab_load,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      aluop,
  output logic            regdst,
  output logic            memtoreg,
  output logic            reg_write,
  output logic            illegal_op,
  output logic            mem_err,
  output logic [3:0]      state_dbg
);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif
  state_e state_q, state_d;
  logic   err_raw;
  logic   unused_zero;
  assign unused_zero = zero;
  assign state_dbg = state_q;
  // next state and Moore outputs; enables are forced off while reset is held
  always_comb begin
    state_d       = S_FETCH;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pcsrc         = PC_ALU;
    ab_load       = 1'b0;
    alusrca       = 1'b0;
    alusrcb       = SRCB_B;
    aluop         = ALU_ADD;
    regdst        = 1'b0;
    memtoreg      = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        alusrcb  = SRCB_4;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ab_load    = 1'b1;
        alusrcb    = SRCB_IMM_SL2;
        illegal_op = !TRAP_EN && decode_state(opcode, S_TRAP) == S_TRAP;
        state_d    = decode_state(opcode, TRAP_EN ? S_TRAP : S_FETCH);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = opcode == OP_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        memtoreg  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        regdst    = 1'b1;
      end
      S_BRANCH: begin
        alusrca       = 1'b1;
        aluop         = ALU_SUB;
        pc_write_cond = 1'b1;
        pcsrc         = PC_ALUOUT;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write = 1'b1;
        pcsrc    = PC_JUMP;
      end
      S_TRAP: begin
        illegal_op = TRAP_EN;
        state_d    = TRAP_EN ? S_TRAP : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      ab_load       = 1'b0;
      illegal_op    = 1'b0;
    end
  end
  // state register
  always_ff @(posedge clk) begin
    state_q <= !rst_n ? S_FETCH : state_d;
  end
  mc_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wait_cyc (mem_req && !mem_ready),
    .clr      (state_d != state_q),
    .mem_err  (err_raw)
  );
  assign mem_err = err_raw && rst_n;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: randomized instruction-level checks of the multicycle control FSM
module tb_multicycle_ctrl_fsm;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;
  localparam int TMO = 4;
  // control word per state, bit order:
  // mem_req mem_write iord ir_write pc_write pc_write_cond pcsrc[2] ab_load alusrca alusrcb[2] aluop[2] regdst memtoreg reg_write illegal_op
  localparam logic [17:0] CTRL [13] = '{
    18'b1_0_0_0_0_0_00_0_0_01_00_0_0_0_0,
    18'b0_0_0_0_0_0_00_1_0_11_00_0_0_0_0,
    18'b0_0_0_0_0_0_00_0_1_10_00_0_0_0_0,
    18'b1_0_1_0_0_0_00_0_0_00_00_0_0_0_0,
    18'b0_0_0_0_0_0_00_0_0_00_00_0_1_1_0,
    18'b1_1_1_0_0_0_00_0_0_00_00_0_0_0_0,
    18'b0_0_0_0_0_0_00_0_1_00_10_0_0_0_0,
    18'b0_0_0_0_0_0_00_0_0_00_00_1_0_1_0,
    18'b0_0_0_0_0_1_01_0_1_00_01_0_0_0_0,
    18'b0_0_0_0_0_0_00_0_1_10_00_0_0_0_0,
    18'b0_0_0_0_0_0_00_0_0_00_00_0_0_1_0,
    18'b0_0_0_0_1_0_10_0_0_00_00_0_0_0_0,
    18'b0_0_0_0_0_0_00_0_0_00_00_0_0_0_1
  };
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, ab_load, alusrca;
  logic regdst, memtoreg, reg_write, illegal_op, mem_err;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic [3:0] state_dbg;
  logic [17:0] obs;
  int n_chk = 0, n_pass = 0, wrun = 0;
  int seq[$];
  always #5 clk = ~clk;
  multicycle_ctrl_fsm #(.OP_W(6), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pcsrc(pcsrc), .ab_load(ab_load),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst),
    .memtoreg(memtoreg), .reg_write(reg_write), .illegal_op(illegal_op),
    .mem_err(mem_err), .state_dbg(state_dbg)
  );
  assign obs = {mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pcsrc, ab_load,
                alusrca, alusrcb, aluop, regdst, memtoreg, reg_write, illegal_op};
  function automatic logic legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, ADDI, JMP};
  endfunction
  // instruction-level state walk for an opcode
  task automatic seq_of(input logic [5:0] op);
    case (op)
      LW:      seq = '{0, 1, 2, 3, 4};
      SW:      seq = '{0, 1, 2, 5};
      RT:      seq = '{0, 1, 6, 7};
      BEQ:     seq = '{0, 1, 8};
      ADDI:    seq = '{0, 1, 9, 10};
      JMP:     seq = '{0, 1, 11};
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      default: seq = '{0, 1, 12};
`else
      default: seq = '{0, 1};
`endif
    endcase
  endtask
  // one clock cycle in expected state s with mem_ready = r
  task automatic cycle(input int s, input logic r);
    logic [17:0] exp;
    logic waiting, werr;
    mem_ready = r;
    exp = CTRL[s];
    if (s == 0 && r) exp[14:13] = 2'b11;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    if (s == 1 && !legal(opcode)) exp[0] = 1'b1;
`endif
    waiting = exp[17] && !r;
    wrun = waiting ? wrun + 1 : 0;
    werr = waiting && (wrun % TMO == 0);
    @(negedge clk);
    n_chk++;
    if (state_dbg !== 4'(s)) $display("FAIL state: got %0d want %0d (op %b)", state_dbg, s, opcode);
    else n_pass++;
    n_chk++;
    if (obs !== exp) $display("FAIL ctrl in state %0d: got %b want %b", s, obs, exp);
    else n_pass++;
    n_chk++;
    if (mem_err !== werr) $display("FAIL mem_err in state %0d wait %0d: got %b want %b", s, wrun, mem_err, werr);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    int s;
    opcode = op;
    zero = z;
    seq_of(op);
    foreach (seq[i]) begin
      s = seq[i];
      if (s == 0 || s == 3 || s == 5) begin
        repeat (s == 0 ? fw : mw) cycle(s, 1'b0);
        cycle(s, 1'b1);
      end else cycle(s, 1'($urandom));
    end
  endtask
  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({mem_req, ir_write, pc_write, pc_write_cond, reg_write, mem_write, ab_load, illegal_op, mem_err} !== 9'b0)
        $display("FAIL reset forced-off outputs: got %b want 0", {mem_req, ir_write, pc_write, pc_write_cond,
                 reg_write, mem_write, ab_load, illegal_op, mem_err});
      else n_pass++;
      if (i > 0) begin
        n_chk++;
        if (state_dbg !== 4'd0) $display("FAIL reset state: got %0d want 0", state_dbg);
        else n_pass++;
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    wrun = 0;
  endtask
  task automatic test_reset();
    apply_reset(2);
  endtask
  task automatic test_lw();
    run_instr(LW, 1'b0, 0, 0);
  endtask
  task automatic test_sw_wait();
    run_instr(SW, 1'b0, 0, 3);
  endtask
  task automatic test_beq();
    run_instr(BEQ, 1'b1, 0, 0);
    run_instr(BEQ, 1'b0, 0, 0);
  endtask
  task automatic test_illegal();
    run_instr(BAD, 1'b0, 0, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    repeat (3) cycle(12, 1'($urandom));
    apply_reset(2);
`endif
    run_instr(JMP, 1'b0, 0, 0);
  endtask
  task automatic test_timeout();
    run_instr(JMP, 1'b0, 9, 0);
    run_instr(LW, 1'b0, 0, 5);
    run_instr(SW, 1'b0, 2, 8);
  endtask
  task automatic test_mid_reset();
    opcode = LW;
    cycle(0, 1'b1);
    cycle(1, 1'b1);
    cycle(2, 1'b0);
    cycle(3, 1'b0);
    cycle(3, 1'b0);
    apply_reset(2);
    run_instr(ADDI, 1'b0, 0, 0);
  endtask
  task automatic test_random();
    logic [5:0] ops [7] = '{LW, SW, RT, BEQ, ADDI, JMP, BAD};
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    int n_ops = 6;
`else
    int n_ops = 7;
`endif
    repeat (60)
      run_instr(ops[$urandom_range(0, n_ops - 1)], 1'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
  endtask
  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
